// File: rtl/noc_perf_pkg.sv
// noc_perf_pkg: shared widths, reset constant and arithmetic helpers for the NoC performance analyser.
package noc_perf_pkg;
    localparam int TW_DEF = 32;
    localparam int CW_DEF = 32;
    localparam int TW_H = 8;
    localparam logic [63:0] LAT_MIN_INIT = '1;

    // Add clamped to w-bit all-ones; operands must already fit in w bits.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int w);
        logic [64:0] s;
        logic [64:0] lim;
        s = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << w) - 65'd1;
        return (s > lim) ? lim[63:0] : s[63:0];
    endfunction

    function automatic logic sat_ovf(input logic [63:0] a, input logic [63:0] b, input int w);
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s > ((65'd1 << w) - 65'd1);
    endfunction

    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) c = c + 7'(v[i]);
        return c;
    endfunction
endpackage

// File: rtl/noc_lat_reduce.sv
// noc_lat_reduce: per-node wrap-safe latencies reduced to sum/min/max for one cycle (combinational).
// With PERF_HIST_EN defined it also counts this cycle's ejections per 8-bin latency histogram bin.
module noc_lat_reduce
    import noc_perf_pkg::*;
#(
    parameter int NN = 12,
    parameter int TW = 32,
    parameter int SW = TW + 4,
    parameter int HW = 4
) (
    input  logic [TW-1:0]    i_now,
    input  logic [NN-1:0]    i_vld,
    input  logic [NN*TW-1:0] i_stamp,
    output logic [SW-1:0]    o_sum,
    output logic [TW-1:0]    o_min,
    output logic [TW-1:0]    o_max
`ifdef PERF_HIST_EN
    ,
    output logic [8*HW-1:0]  o_hcnt
`endif
);
    logic [TW-1:0] w_lat [NN];

    for (genvar k = 0; k < NN; k++) begin : g_lat
        assign w_lat[k] = i_now - i_stamp[k*TW +: TW];
    end

    always_comb begin
        o_sum = '0;
        o_min = '1;
        o_max = '0;
        for (int i = 0; i < NN; i++) begin
            if (i_vld[i]) begin
                o_sum = o_sum + SW'(w_lat[i]);
                o_min = (w_lat[i] < o_min) ? w_lat[i] : o_min;
                o_max = (w_lat[i] > o_max) ? w_lat[i] : o_max;
            end
        end
    end

`ifdef PERF_HIST_EN
    logic [2:0] w_bin;
    always_comb begin
        o_hcnt = '0;
        w_bin = '0;
        for (int i = 0; i < NN; i++) begin
            // Latencies beyond the 8-bit histogram range fold into the top bin.
            w_bin = (w_lat[i] > TW'((1 << TW_H) - 1)) ? 3'd7 : w_lat[i][TW_H-1 -: 3];
            if (i_vld[i]) o_hcnt[w_bin*HW +: HW] = o_hcnt[w_bin*HW +: HW] + HW'(1);
        end
    end
`endif
endmodule

// File: rtl/noc_perf_analyser.sv
// noc_perf_analyser: network-wide packet count, latency and in-flight statistics for the mesh NoC.
// Optional PERF_HIST_EN adds an 8-bin saturating latency histogram on output hist.
module noc_perf_analyser
    import noc_perf_pkg::*;
#(
    parameter int DIMX = 4,
    parameter int DIMY = 3,
    parameter int TW = TW_DEF,
    parameter int CW = CW_DEF,
    localparam int NN = DIMX * DIMY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             meas_en,
    input  logic [NN-1:0]    inj_vld,
    input  logic [NN-1:0]    ej_vld,
    input  logic [NN*TW-1:0] ej_stamp,
    output logic [TW-1:0]    now,
    output logic [CW-1:0]    inj_cnt,
    output logic [CW-1:0]    ej_cnt,
    output logic [CW-1:0]    in_flight,
    output logic [CW-1:0]    lat_sum,
    output logic [TW-1:0]    lat_min,
    output logic [TW-1:0]    lat_max,
    output logic             sat
`ifdef PERF_HIST_EN
    ,
    output logic [8*CW-1:0]  hist
`endif
);
    localparam int HW = $clog2(NN + 1);
    localparam int SW = TW + HW;

    logic [SW-1:0] w_sum;
    logic [TW-1:0] w_min, w_max;
    logic [CW-1:0] w_inj_n, w_ej_n, w_sum_n;
    logic          w_ovf;
    logic [7:0]    w_hovf;

`ifdef PERF_HIST_EN
    logic [8*HW-1:0] w_hcnt;
`endif

    noc_lat_reduce #(.NN(NN), .TW(TW), .SW(SW), .HW(HW)) u_reduce (
        .i_now   (now),
        .i_vld   (ej_vld),
        .i_stamp (ej_stamp),
        .o_sum   (w_sum),
        .o_min   (w_min),
        .o_max   (w_max)
`ifdef PERF_HIST_EN
        ,
        .o_hcnt  (w_hcnt)
`endif
    );

    always_comb begin
        w_inj_n = CW'(sat_add(64'(inj_cnt), 64'(popcount(64'(inj_vld))), CW));
        w_ej_n  = CW'(sat_add(64'(ej_cnt), 64'(popcount(64'(ej_vld))), CW));
        w_sum_n = CW'(sat_add(64'(lat_sum), 64'(w_sum), CW));
        w_ovf   = sat_ovf(64'(inj_cnt), 64'(popcount(64'(inj_vld))), CW)
                | sat_ovf(64'(ej_cnt), 64'(popcount(64'(ej_vld))), CW)
                | sat_ovf(64'(lat_sum), 64'(w_sum), CW)
                | (|w_hovf);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            now       <= '0;
            inj_cnt   <= '0;
            ej_cnt    <= '0;
            in_flight <= '0;
            lat_sum   <= '0;
            lat_min   <= TW'(LAT_MIN_INIT);
            lat_max   <= '0;
            sat       <= 1'b0;
        end else begin
            now <= now + TW'(1);
            if (clr) begin
                inj_cnt   <= '0;
                ej_cnt    <= '0;
                in_flight <= '0;
                lat_sum   <= '0;
                lat_min   <= TW'(LAT_MIN_INIT);
                lat_max   <= '0;
                sat       <= 1'b0;
            end else if (meas_en) begin
                inj_cnt   <= w_inj_n;
                ej_cnt    <= w_ej_n;
                // Derived from the clamped counts so a protocol error never reads negative.
                in_flight <= (w_inj_n > w_ej_n) ? w_inj_n - w_ej_n : '0;
                lat_sum   <= w_sum_n;
                lat_min   <= (w_min < lat_min) ? w_min : lat_min;
                lat_max   <= (w_max > lat_max) ? w_max : lat_max;
                sat       <= sat | w_ovf;
            end
        end
    end

`ifdef PERF_HIST_EN
    for (genvar b = 0; b < 8; b++) begin : g_hist
        logic [CW-1:0] r_bin;
        assign w_hovf[b] = sat_ovf(64'(r_bin), 64'(w_hcnt[b*HW +: HW]), CW);
        assign hist[b*CW +: CW] = r_bin;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) r_bin <= '0;
            else if (clr) r_bin <= '0;
            else if (meas_en) r_bin <= CW'(sat_add(64'(r_bin), 64'(w_hcnt[b*HW +: HW]), CW));
        end
    end
`else
    assign w_hovf = '0;
`endif
endmodule

// File: tb/tb_noc_perf_analyser.sv
// tb_noc_perf_analyser: randomized and directed scoreboard bench for noc_perf_analyser (TW=CW=8).
module tb_noc_perf_analyser;
    localparam int DIMX = 4, DIMY = 3, NN = 12, TW = 8, CW = 8;
    localparam int MAXV = 255;

    logic clk = 1'b0, rst = 1'b1, clr = 1'b0, meas_en = 1'b0;
    logic [NN-1:0] inj_vld = '0, ej_vld = '0;
    logic [NN*TW-1:0] ej_stamp = '0;
    logic [TW-1:0] now, lat_min, lat_max;
    logic [CW-1:0] inj_cnt, ej_cnt, in_flight, lat_sum;
    logic sat;
`ifdef PERF_HIST_EN
    logic [8*CW-1:0] hist;
`endif

    noc_perf_analyser #(.DIMX(DIMX), .DIMY(DIMY), .TW(TW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .clr(clr), .meas_en(meas_en),
        .inj_vld(inj_vld), .ej_vld(ej_vld), .ej_stamp(ej_stamp),
        .now(now), .inj_cnt(inj_cnt), .ej_cnt(ej_cnt), .in_flight(in_flight),
        .lat_sum(lat_sum), .lat_min(lat_min), .lat_max(lat_max), .sat(sat)
`ifdef PERF_HIST_EN
        , .hist(hist)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int now, inj, ej, inf, sum, mn, mx, sat;
    } exp_t;

    exp_t q[$];
    int n_chk = 0, n_err = 0;
    int m_now, m_inj, m_ej, m_sum, m_mn, m_mx, m_sat;
    int st[NN];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        m_inj = 0; m_ej = 0; m_sum = 0; m_mn = MAXV; m_mx = 0; m_sat = 0;
    endfunction

    // Called at a falling edge: drive one cycle of inputs, predict the state after the next rising edge.
    task automatic step(input logic c, input logic e, input logic [NN-1:0] iv, input logic [NN-1:0] ev);
        exp_t x;
        int lat;
        clr = c; meas_en = e; inj_vld = iv; ej_vld = ev;
        for (int i = 0; i < NN; i++) ej_stamp[i*TW +: TW] = TW'(st[i]);
        if (c) model_clear();
        else if (e) begin
            m_inj += $countones(iv);
            if (m_inj > MAXV) begin m_inj = MAXV; m_sat = 1; end
            m_ej += $countones(ev);
            if (m_ej > MAXV) begin m_ej = MAXV; m_sat = 1; end
            for (int i = 0; i < NN; i++) begin
                if (ev[i]) begin
                    lat = (m_now - st[i] + 256) % 256;
                    m_sum += lat;
                    if (lat < m_mn) m_mn = lat;
                    if (lat > m_mx) m_mx = lat;
                end
            end
            if (m_sum > MAXV) begin m_sum = MAXV; m_sat = 1; end
        end
        m_now = (m_now + 1) % 256;
        x.now = m_now; x.inj = m_inj; x.ej = m_ej;
        x.inf = (m_inj > m_ej) ? m_inj - m_ej : 0;
        x.sum = m_sum; x.mn = m_mn; x.mx = m_mx; x.sat = m_sat;
        q.push_back(x);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between edges; outputs are checked before any clock edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_now", now, 0); chk("rst_inj", inj_cnt, 0); chk("rst_ej", ej_cnt, 0);
        chk("rst_inf", in_flight, 0); chk("rst_sum", lat_sum, 0); chk("rst_min", lat_min, MAXV);
        chk("rst_max", lat_max, 0); chk("rst_sat", sat, 0);
        @(negedge clk);
        rst = 1'b0; clr = 1'b0; meas_en = 1'b0; inj_vld = '0; ej_vld = '0;
        model_clear();
        m_now = 0;
    endtask

    always begin
        exp_t x;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("now", now, x.now); chk("inj_cnt", inj_cnt, x.inj); chk("ej_cnt", ej_cnt, x.ej);
            chk("in_flight", in_flight, x.inf); chk("lat_sum", lat_sum, x.sum);
            chk("lat_min", lat_min, x.mn); chk("lat_max", lat_max, x.mx); chk("sat", sat, x.sat);
        end
    end

    initial begin
        for (int i = 0; i < NN; i++) st[i] = 0;
        @(negedge clk);
        do_reset();
        repeat (10) step(1'b0, 1'b1, '0, '0);
        do_reset();
        st[5] = 5;
        for (int t = 0; t <= 17; t++) step(1'b0, 1'b1, (t == 5) ? 12'h001 : 12'h000, (t == 17) ? 12'h020 : 12'h000);
        step(1'b1, 1'b1, '0, '0);
        st[2] = (m_now - 4 + 256) % 256;
        st[3] = (m_now - 9 + 256) % 256;
        step(1'b0, 1'b1, 12'hFFF, 12'h00C);
        step(1'b1, 1'b0, '0, '0);
        while (m_now != 0) step(1'b0, 1'b0, '0, '0);
        while (m_now != 3) step(1'b0, 1'b0, '0, '0);
        st[7] = 8'hFE;
        step(1'b0, 1'b1, '0, 12'h080);
        step(1'b1, 1'b1, '0, '0);
        repeat (21) step(1'b0, 1'b1, 12'hFFF, '0);
        step(1'b0, 1'b1, 12'h003, '0);
        step(1'b0, 1'b1, 12'h007, '0);
        step(1'b1, 1'b1, 12'hFFF, 12'hFFF);
        st[1] = m_now;
        step(1'b0, 1'b1, 12'h00F, 12'h002);
        repeat (5) step(1'b0, 1'b0, 12'hFFF, 12'h0F0);
        step(1'b0, 1'b1, 12'h0F0, 12'h001);
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NN; i++)
                st[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                                    : (m_now - int'($urandom_range(0, 15)) + 256) % 256;
            step(($urandom_range(0, 14) == 0), ($urandom_range(0, 4) != 0),
                 NN'($urandom) & NN'($urandom), NN'($urandom) & NN'($urandom));
        end
        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/noc_perf_analyser.md
Name: noc_perf_analyser

Overview:
- Global, cycle-synchronous performance analyser for the DIMX x DIMY mesh NoC.
- Sits beside the mesh top level. Each node reports packet injection and ejection events.
- The block keeps a free-running timestamp and accumulates network-wide totals: packet counts, latency sum, min/max latency and in-flight packets.
- Results are presented as registered outputs for benches and software readout.

Parameters:
- DIMX, 4, mesh X dimension
- DIMY, 3, mesh Y dimension
- NN, DIMX*DIMY (derived localparam), number of nodes
- TW, 32, timestamp/latency width
- CW, 32, counter and accumulator width

Ports:
- clk  in  1  single system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear of all statistics; timestamp keeps running
- meas_en  in  1  measurement window; events are counted only while high
- inj_vld  in  NN  bit i = node i injected one packet this cycle
- ej_vld  in  NN  bit i = node i ejected one packet this cycle
- ej_stamp  in  NN*TW  injection timestamp carried by the packet ejected at node i; slice i = bits [i*TW +: TW]
- now  out  TW  free-running cycle counter, stamped into packets by sources
- inj_cnt  out  CW  packets injected
- ej_cnt  out  CW  packets ejected
- in_flight  out  CW  inj_cnt minus ej_cnt
- lat_sum  out  CW  sum of latencies of ejected packets
- lat_min  out  TW  minimum latency observed
- lat_max  out  TW  maximum latency observed
- sat  out  1  sticky flag: some counter saturated

Behaviour:
- Reset (rst high, asynchronous): now=0, inj_cnt=0, ej_cnt=0, in_flight=0, lat_sum=0, lat_min=all-ones, lat_max=0, sat=0.
- now increments by 1 every cycle and wraps modulo 2^TW. It is not affected by clr or meas_en.
- Latency of node i = (now - ej_stamp[i]) mod 2^TW, so wrap-around is handled. A stamp equal to now gives latency 0.
- Per cycle with meas_en=1:
  - inj_cnt += popcount(inj_vld); ej_cnt += popcount(ej_vld).
  - lat_sum += sum of the latencies of all valid ejections.
  - lat_min and lat_max are updated with the min/max over the valid ejections of that cycle.
  - Simultaneous events at any number of nodes are all accounted for in the same cycle.
- With meas_en=0, inputs are ignored and statistics hold.
- All outputs are registered. An event in cycle N is visible on the outputs after edge N+1 (one-cycle latency).
- Saturation: inj_cnt, ej_cnt and lat_sum clamp at 2^CW-1 instead of wrapping, and sat is set. sat is cleared only by rst or clr.
- in_flight:
  - Computed from the saturated counters; it is never negative.
  - If ej_cnt exceeds inj_cnt (protocol error), in_flight reads 0.
- clr: takes effect on the next edge and returns the statistics to their reset values, now excepted. clr has priority over events in the same cycle, so those events are discarded.
- With no ejections counted, lat_min stays all-ones and lat_max stays 0. Readers treat this as "no data".
- Reset asserted mid-operation clears everything immediately. Counting resumes on the first edge after deassertion.

Optional Feature:
- PERF_HIST_EN: when defined, add an 8-bin latency histogram.
  - Bins are defined by the 3 MSBs of min(latency, 2^(TW_H)-1), where TW_H=8 (localparam).
  - Each bin is a CW-bit saturating counter, exposed on output hist, NN-independent, width 8*CW.
  - Bins are cleared by rst and clr.
  - Multiple same-cycle ejections in one bin add together.
- When not defined, the hist port and its logic are absent.

Decomposition:
- Package noc_perf_pkg holds:
  - TW and CW defaults
  - the all-ones LAT_MIN_INIT constant
  - the saturating-add function
  - the popcount function
- One sub-module, noc_lat_reduce: computes the per-node latencies and reduces them to sum/min/max for one cycle. It is purely combinational.

Test Plan:
- Reset then idle 10 cycles, meas_en=1, no events -> now=10, all counts 0, lat_min=FFFFFFFF, lat_max=0.
- Node 0 injects at now=5; node 5 ejects it with ej_stamp=5 at now=17 -> next cycle: inj_cnt=1, ej_cnt=1, in_flight=0, lat_sum=12, lat_min=lat_max=12.
- Same cycle, inj_vld=all 12 bits set and ej_vld bits 2 and 3 set, with latencies 4 and 9 -> inj_cnt+=12, ej_cnt+=2, lat_sum+=13, lat_min=4, lat_max=9.
- Force now near wrap by running 2^TW-3 cycles (TW reduced to 8 in the bench): stamp 0xFE ejected at now=0x03 -> latency 5.
- Preload inj_cnt to 2^CW-2 (CW=8), then inject 3 -> inj_cnt=255, sat=1. Then clr -> counts 0, sat=0, now unaffected.
- meas_en=0 with events present -> statistics unchanged. Assert rst mid-run -> all outputs at reset values immediately, without waiting for a clock edge.
